// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end: 2-flop rx synchronizer, bit-timing FSM and a
// small circular FIFO that presents received bytes on a valid/ready port.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bidx;
  logic [7:0]       shift;
  logic             rx_meta;
  logic             rx_s;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;

  // Two-flop synchronizer; both stages reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Bit-timing FSM: mid-bit sampling of start, data and stop bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bidx      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              cnt   <= '0;
              bidx  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            bidx <= bidx + 1'b1;
            if (bidx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold off new starts until the line leaves the break condition.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data shift register, LSB first; pure data path, no reset needed.
  always_ff @(posedge clk) begin
    if (state == DATA && cnt == CNT_LAST) shift[bidx] <= rx_s;
  end

  assign busy  = (state != IDLE);
  assign push  = (state == STOP) && (cnt == CNT_LAST) && rx_s;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);

  // FIFO pointers and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= shift;
  end

  assign out_valid = !empty;
  // Gate the head entry so out_data reads zero whenever nothing is queued.
  assign out_data  = out_valid ? mem[rptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed frames, scoreboard
// queue of expected bytes, and a monitor that compares on every pop.
module tb_uart_rx_frontend;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_frontend #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         rise_cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_b;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    fall_cyc = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) tick(1);
    out_ready = 1'b0;
    check("drain_valid_low", out_valid, 0);
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: pulse accounting and scoreboard compare on each accepted byte.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (out_valid && !prev_valid) rise_cyc = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", out_data);
          end else begin
            exp_b = exp_q.pop_front();
            check("pop_data", out_data, exp_b);
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    out_ready = 1'b0;
    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;

    // 1: idle line
    tick(100);
    check("idle_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_pulses", fe_cnt + ov_cnt, 0);

    // 2: single byte, held until accepted
    send_byte(8'hA5, 1'b1);
    check("latency", rise_cyc - fall_cyc, 155);
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, 8'hA5);
    tick(20);
    check("a5_hold_data", out_data, 8'hA5);
    check("a5_hold_valid", out_valid, 1);
    exp_q.push_back(8'hA5);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("a5_valid_fall", out_valid, 0);
    check("a5_popped", exp_q.size(), 0);

    // 3: five back-to-back bytes into a 4-deep FIFO
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
    for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
    check("ovr_count", ov_cnt, 1);
    check("full_head", out_data, 8'h01);
    drain();

    // 4: framing error with stop bit low, line held in break
    send_byte(8'h3C, 1'b0);
    tick(40);
    check("brk_busy", busy, 1);
    check("ferr_count", fe_cnt, 1);
    check("ferr_no_push", out_valid, 0);
    rx = 1'b1;
    tick(5);
    check("brk_busy_clear", busy, 0);

    // 5: short glitch on idle line
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(2);
    check("glitch_busy", busy, 1);
    tick(20);
    check("glitch_busy_clear", busy, 0);
    check("glitch_no_byte", out_valid, 0);
    check("glitch_no_pulse", fe_cnt * 16 + ov_cnt, 17);

    // 6: reset in the middle of a frame with two bytes queued
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("pre_rst_valid", out_valid, 1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h5A >> i;
      tick(CPB);
    end
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_pulses", {frame_err, overrun}, 0);
    tick(10);
    exp_q.push_back(8'h77);
    out_ready = 1'b1;
    send_byte(8'h77, 1'b1);
    tick(3);
    out_ready = 1'b0;
    check("post_rst_queue", exp_q.size(), 0);
    check("post_rst_valid", out_valid, 0);
    check("final_ferr", fe_cnt, 1);
    check("final_ovr", ov_cnt, 1);
    check("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
